ascon_perm_iter: RTL and testbench

//  Iterative ASCON-p permutation core with a configurable number of rounds unrolled per cycle and per-transaction round count.

---
 rtl/ascon_perm_iter.sv | 162 ++++++++++++++++
 tb/tb_ascon_perm_iter.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_perm_iter.sv
// ascon_perm_iter: iterative ASCON-p core, UNROLL rounds per clock.
// Define ASCON_PERM_ZEROIZE_EN to clear the state once a result is taken.
module ascon_perm_iter #(
  parameter int UNROLL     = 1,
  parameter int MAX_ROUNDS = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [319:0] state_in,
  input  logic [3:0]   rounds_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [319:0] state_out,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fsm_t;

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 3 ||
        UNROLL == 4 || UNROLL == 6)) begin : g_bad_unroll
    $error("ascon_perm_iter: UNROLL must be 1,2,3,4 or 6");
  end

  if (MAX_ROUNDS != 12) begin : g_bad_rounds
    $error("ascon_perm_iter: MAX_ROUNDS must be 12");
  end

  localparam logic [3:0] LAST = 4'(MAX_ROUNDS);
  localparam logic [3:0] STEP = 4'(UNROLL);

  fsm_t         fsm, fsm_n;
  logic [319:0] x, x_n;
  logic [3:0]   rnd_cnt, rnd_cnt_n;
  logic [3:0]   rounds_sat;
  logic [3:0]   left, step;
  logic [319:0] run_state;
  logic         accept;

  function automatic logic [63:0] ror(
    input logic [63:0] v,
    input int          n
  );
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [319:0] ascon_round(
    input logic [319:0] s,
    input logic [3:0]   j
  );
    logic [63:0] a0, a1, a2, a3, a4;
    logic [63:0] t0, t1, t2, t3, t4;
    logic [3:0]  jc;
    a0 = s[319:256];
    a1 = s[255:192];
    a2 = s[191:128];
    a3 = s[127:64];
    a4 = s[63:0];
    jc = 4'hF - j;
    a2 = a2 ^ {56'd0, jc, j};
    // bitsliced 5-bit S-box
    a0 = a0 ^ a4;
    a4 = a4 ^ a3;
    a2 = a2 ^ a1;
    t0 = ~a0 & a1;
    t1 = ~a1 & a2;
    t2 = ~a2 & a3;
    t3 = ~a3 & a4;
    t4 = ~a4 & a0;
    a0 = a0 ^ t1;
    a1 = a1 ^ t2;
    a2 = a2 ^ t3;
    a3 = a3 ^ t4;
    a4 = a4 ^ t0;
    a1 = a1 ^ a0;
    a0 = a0 ^ a4;
    a3 = a3 ^ a2;
    a2 = ~a2;
    a0 = a0 ^ ror(a0, 19) ^ ror(a0, 28);
    a1 = a1 ^ ror(a1, 61) ^ ror(a1, 39);
    a2 = a2 ^ ror(a2, 1)  ^ ror(a2, 6);
    a3 = a3 ^ ror(a3, 10) ^ ror(a3, 17);
    a4 = a4 ^ ror(a4, 7)  ^ ror(a4, 41);
    return {a0, a1, a2, a3, a4};
  endfunction

  assign rounds_sat = (rounds_in > LAST) ? LAST : rounds_in;
  assign left       = LAST - rnd_cnt;
  assign step       = (left < STEP) ? left : STEP;

  // stages whose round index runs past the last round pass through
  always_comb begin
    logic [319:0] s;
    logic [4:0]   j;
    s = x;
    j = '0;
    for (int k = 0; k < UNROLL; k++) begin
      j = {1'b0, rnd_cnt} + 5'(k);
      if (j < {1'b0, LAST})
        s = ascon_round(s, j[3:0]);
    end
    run_state = s;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm     <= IDLE;
      x       <= '0;
      rnd_cnt <= '0;
    end else begin
      fsm     <= fsm_n;
      x       <= x_n;
      rnd_cnt <= rnd_cnt_n;
    end
  end

  always_comb begin
    fsm_n     = fsm;
    x_n       = x;
    rnd_cnt_n = rnd_cnt;
    in_ready  = 1'b0;
    unique case (fsm)
      IDLE:    in_ready = 1'b1;
      HOLD:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    accept = in_valid & in_ready;
    if (accept) begin
      x_n       = state_in;
      rnd_cnt_n = LAST - rounds_sat;
      fsm_n     = (rounds_sat == 4'd0) ? HOLD : RUN;
    end else begin
      unique case (fsm)
        RUN: begin
          x_n       = run_state;
          rnd_cnt_n = rnd_cnt + step;
          if (rnd_cnt + step == LAST)
            fsm_n = HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            fsm_n = IDLE;
`ifdef ASCON_PERM_ZEROIZE_EN
            x_n = '0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = (fsm == HOLD);
  assign busy      = (fsm == RUN);
  assign state_out = x;

endmodule

// File: tb/tb_ascon_perm_iter.sv
// tb_ascon_perm_iter: directed checks of ascon_perm_iter at UNROLL 1 and 4
// against a table-driven ASCON-p reference.
module tb_ascon_perm_iter;

  logic         clk = 1'b0;
  logic         reset;
  logic         iv   [2];
  logic         irdy [2];
  logic [319:0] sin  [2];
  logic [3:0]   rin  [2];
  logic         ov   [2];
  logic         ordy [2];
  logic [319:0] sout [2];
  logic         bsy  [2];

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  localparam logic [7:0] RC [12] = '{
    8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
  };

  localparam logic [319:0] ST_A = {
    64'h0123456789abcdef, 64'hfedcba9876543210,
    64'h0f1e2d3c4b5a6978, 64'h8877665544332211,
    64'hdeadbeefcafef00d
  };
  localparam logic [319:0] ST_B = {
    64'h00400c0000000100, 64'h0, 64'h0, 64'h0, 64'h0
  };
  localparam logic [319:0] ST_C = {
    64'hffffffffffffffff, 64'h5555555555555555,
    64'haaaaaaaaaaaaaaaa, 64'h0000000000000001,
    64'h8000000000000000
  };

  ascon_perm_iter #(.UNROLL(1), .MAX_ROUNDS(12)) u_p1 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (iv[0]),
    .in_ready  (irdy[0]),
    .state_in  (sin[0]),
    .rounds_in (rin[0]),
    .out_valid (ov[0]),
    .out_ready (ordy[0]),
    .state_out (sout[0]),
    .busy      (bsy[0])
  );

  ascon_perm_iter #(.UNROLL(4), .MAX_ROUNDS(12)) u_p4 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (iv[1]),
    .in_ready  (irdy[1]),
    .state_in  (sin[1]),
    .rounds_in (rin[1]),
    .out_valid (ov[1]),
    .out_ready (ordy[1]),
    .state_out (sout[1]),
    .busy      (bsy[1])
  );

  always #5 clk = ~clk;

  // column-wise S-box lookup, last r of the 12 rounds
  function automatic logic [319:0] ref_perm(
    input logic [319:0] s,
    input int           r
  );
    logic [63:0] w [5];
    logic [4:0]  c, o;
    for (int i = 0; i < 5; i++)
      w[i] = s[319 - 64*i -: 64];
    for (int rr = 12 - r; rr < 12; rr++) begin
      w[2] = w[2] ^ {56'd0, RC[rr]};
      for (int b = 0; b < 64; b++) begin
        c = {w[0][b], w[1][b], w[2][b], w[3][b], w[4][b]};
        o = SBOX[c];
        w[0][b] = o[4];
        w[1][b] = o[3];
        w[2][b] = o[2];
        w[3][b] = o[1];
        w[4][b] = o[0];
      end
      w[0] = w[0] ^ {w[0][18:0], w[0][63:19]}
                  ^ {w[0][27:0], w[0][63:28]};
      w[1] = w[1] ^ {w[1][60:0], w[1][63:61]}
                  ^ {w[1][38:0], w[1][63:39]};
      w[2] = w[2] ^ {w[2][0],    w[2][63:1]}
                  ^ {w[2][5:0],  w[2][63:6]};
      w[3] = w[3] ^ {w[3][9:0],  w[3][63:10]}
                  ^ {w[3][16:0], w[3][63:17]};
      w[4] = w[4] ^ {w[4][6:0],  w[4][63:7]}
                  ^ {w[4][40:0], w[4][63:41]};
    end
    return {w[0], w[1], w[2], w[3], w[4]};
  endfunction

  function automatic logic [319:0] idle_exp(input logic [319:0] r);
`ifdef ASCON_PERM_ZEROIZE_EN
    return '0;
`else
    return r;
`endif
  endfunction

  task automatic send(
    input int           d,
    input logic [319:0] st,
    input logic [3:0]   r
  );
    iv[d]  = 1'b1;
    sin[d] = st;
    rin[d] = r;
    @(posedge clk);
    #1;
    iv[d] = 1'b0;
  endtask

  task automatic wait_out(input int d, output int n);
    n = 0;
    while (!ov[d] && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      iv[d]   = 1'b0;
      ordy[d] = 1'b0;
      sin[d]  = '0;
      rin[d]  = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (irdy[d] !== 1'b1 || ov[d] !== 1'b0 || bsy[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_ctl[%0d]: got rdy=%b ov=%b busy=%b want 1 0 0",
                 d, irdy[d], ov[d], bsy[d]);
      end
      n_chk++;
      if (sout[d] !== 320'd0) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: got %h want 0", d, sout[d]);
      end
    end
  endtask

  task automatic test_p12_zero();
    int n;
    logic [319:0] exp;
    exp = ref_perm(320'd0, 12);
    send(0, 320'd0, 4'd12);
    n_chk++;
    if (bsy[0] !== 1'b1 || ov[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL p12_run: got busy=%b ov=%b want 1 0", bsy[0], ov[0]);
    end
    wait_out(0, n);
    n_chk++;
    if (n != 12) begin
      n_fail++;
      $display("FAIL p12_latency: got %0d want 12", n);
    end
    n_chk++;
    if (sout[0] !== exp) begin
      n_fail++;
      $display("FAIL p12_state: got %h want %h", sout[0], exp);
    end
    ordy[0] = 1'b1;
    @(posedge clk);
    #1;
    ordy[0] = 1'b0;
    n_chk++;
    if (ov[0] !== 1'b0 || irdy[0] !== 1'b1 || sout[0] !== idle_exp(exp)) begin
      n_fail++;
      $display("FAIL p12_idle: got ov=%b rdy=%b st=%h want 0 1 %h",
               ov[0], irdy[0], sout[0], idle_exp(exp));
    end
  endtask

  task automatic test_unroll4();
    int n;
    logic [319:0] exp;
    exp = ref_perm(ST_A, 6);
    send(1, ST_A, 4'd6);
    wait_out(1, n);
    n_chk++;
    if (n != 2) begin
      n_fail++;
      $display("FAIL u4_r6_latency: got %0d want 2", n);
    end
    n_chk++;
    if (sout[1] !== exp) begin
      n_fail++;
      $display("FAIL u4_r6_state: got %h want %h", sout[1], exp);
    end
    ordy[1] = 1'b1;
    exp = ref_perm(ST_B, 12);
    send(1, ST_B, 4'd12);
    ordy[1] = 1'b0;
    wait_out(1, n);
    n_chk++;
    if (n != 3 || sout[1] !== exp) begin
      n_fail++;
      $display("FAIL u4_r12: got n=%0d st=%h want 3 %h", n, sout[1], exp);
    end
    ordy[1] = 1'b1;
    exp = ref_perm(ST_C, 5);
    send(1, ST_C, 4'd5);
    ordy[1] = 1'b0;
    wait_out(1, n);
    n_chk++;
    if (n != 2 || sout[1] !== exp) begin
      n_fail++;
      $display("FAIL u4_r5: got n=%0d st=%h want 2 %h", n, sout[1], exp);
    end
    ordy[1] = 1'b1;
    @(posedge clk);
    #1;
    ordy[1] = 1'b0;
  endtask

  task automatic test_rounds_edge();
    int n;
    logic [319:0] exp;
    send(0, ST_A, 4'd0);
    n_chk++;
    if (ov[0] !== 1'b1 || bsy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL r0_valid: got ov=%b busy=%b want 1 0", ov[0], bsy[0]);
    end
    n_chk++;
    if (sout[0] !== ST_A) begin
      n_fail++;
      $display("FAIL r0_state: got %h want %h", sout[0], ST_A);
    end
    ordy[0] = 1'b1;
    @(posedge clk);
    #1;
    ordy[0] = 1'b0;
    exp = ref_perm(ST_C, 12);
    send(1, ST_C, 4'd15);
    wait_out(1, n);
    n_chk++;
    if (n != 3 || sout[1] !== exp) begin
      n_fail++;
      $display("FAIL r15_sat: got n=%0d st=%h want 3 %h", n, sout[1], exp);
    end
    ordy[1] = 1'b1;
    @(posedge clk);
    #1;
    ordy[1] = 1'b0;
  endtask

  task automatic test_hold_backpressure();
    int n;
    logic [319:0] exp;
    logic [319:0] exp2;
    exp  = ref_perm(ST_B, 4);
    exp2 = ref_perm(ST_C, 1);
    send(1, ST_B, 4'd4);
    wait_out(1, n);
    n_chk++;
    if (n != 1) begin
      n_fail++;
      $display("FAIL hold_latency: got %0d want 1", n);
    end
    iv[1]  = 1'b1;
    sin[1] = ST_A;
    rin[1] = 4'd3;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      n_chk++;
      if (ov[1] !== 1'b1 || irdy[1] !== 1'b0 || sout[1] !== exp) begin
        n_fail++;
        $display("FAIL hold_stable[%0d]: got ov=%b rdy=%b st=%h want 1 0 %h",
                 c, ov[1], irdy[1], sout[1], exp);
      end
    end
    ordy[1] = 1'b1;
    sin[1]  = ST_C;
    rin[1]  = 4'd1;
    #1;
    n_chk++;
    if (irdy[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_ready: got %b want 1", irdy[1]);
    end
    @(posedge clk);
    #1;
    iv[1]   = 1'b0;
    ordy[1] = 1'b0;
    n_chk++;
    if (bsy[1] !== 1'b1 || ov[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_reaccept: got busy=%b ov=%b want 1 0",
               bsy[1], ov[1]);
    end
    wait_out(1, n);
    n_chk++;
    if (n != 1 || sout[1] !== exp2) begin
      n_fail++;
      $display("FAIL hold_job2: got n=%0d st=%h want 1 %h", n, sout[1], exp2);
    end
    ordy[1] = 1'b1;
    @(posedge clk);
    #1;
    ordy[1] = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int n;
    logic [319:0] exp;
    exp = ref_perm(ST_C, 2);
    send(0, ST_A, 4'd12);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_chk++;
    if (ov[0] !== 1'b0 || irdy[0] !== 1'b1 || bsy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_run_ctl: got ov=%b rdy=%b busy=%b want 0 1 0",
               ov[0], irdy[0], bsy[0]);
    end
    n_chk++;
    if (sout[0] !== 320'd0) begin
      n_fail++;
      $display("FAIL rst_run_state: got %h want 0", sout[0]);
    end
    send(0, ST_C, 4'd2);
    wait_out(0, n);
    n_chk++;
    if (n != 2 || sout[0] !== exp) begin
      n_fail++;
      $display("FAIL rst_run_job: got n=%0d st=%h want 2 %h", n, sout[0], exp);
    end
    ordy[0] = 1'b1;
    @(posedge clk);
    #1;
    ordy[0] = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n;
    logic [319:0] ea;
    logic [319:0] eb;
    ea = ref_perm(ST_B, 3);
    eb = ref_perm(ST_A, 3);
    ordy[0] = 1'b1;
    send(0, ST_B, 4'd3);
    wait_out(0, n);
    n_chk++;
    if (n != 3 || sout[0] !== ea) begin
      n_fail++;
      $display("FAIL b2b_a: got n=%0d st=%h want 3 %h", n, sout[0], ea);
    end
    send(0, ST_A, 4'd3);
    n_chk++;
    if (bsy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept: got busy=%b want 1", bsy[0]);
    end
    wait_out(0, n);
    n_chk++;
    if (n != 3 || sout[0] !== eb) begin
      n_fail++;
      $display("FAIL b2b_b: got n=%0d st=%h want 3 %h", n, sout[0], eb);
    end
    @(posedge clk);
    #1;
    ordy[0] = 1'b0;
    n_chk++;
    if (ov[0] !== 1'b0 || sout[0] !== idle_exp(eb)) begin
      n_fail++;
      $display("FAIL b2b_idle: got ov=%b st=%h want 0 %h",
               ov[0], sout[0], idle_exp(eb));
    end
  endtask

  initial begin
    test_reset();
    test_p12_zero();
    test_unroll4();
    test_rounds_edge();
    test_hold_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
